// File: rtl/mul_mac_seq_if.sv
// Control bundle between the program sequencer / register file / multiplier
// and the MAC sequencer. slave = the sequencer, master = whoever drives it.
interface mul_mac_seq_if #(
  parameter int RF_ADDRSIZE = 4,
  parameter int LEN_W       = 5
);
  logic                   start;
  logic [LEN_W-1:0]       len;
  logic [RF_ADDRSIZE-1:0] x_base;
  logic [RF_ADDRSIZE-1:0] y_base;
  logic [3:0]             dtsts;
  logic                   sub;
  logic                   wb_en;
  logic [RF_ADDRSIZE-1:0] rn_addr;
  logic                   stall;
  logic                   mul_ps_mv;

  logic [RF_ADDRSIZE-1:0] rf_rx_addr;
  logic [RF_ADDRSIZE-1:0] rf_ry_addr;
  logic                   ps_mul_en;
  logic                   ps_mul_otreg;
  logic [3:0]             ps_mul_dtsts;
  logic [1:0]             ps_mul_cls;
  logic                   rf_wr_en;
  logic [RF_ADDRSIZE-1:0] rf_wr_addr;
  logic                   busy;
  logic                   done;

  modport slave (
    input  start, len, x_base, y_base, dtsts, sub, wb_en, rn_addr, stall, mul_ps_mv,
    output rf_rx_addr, rf_ry_addr, ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls,
           rf_wr_en, rf_wr_addr, busy, done
  );

  modport master (
    output start, len, x_base, y_base, dtsts, sub, wb_en, rn_addr, stall, mul_ps_mv,
    input  rf_rx_addr, rf_ry_addr, ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls,
           rf_wr_en, rf_wr_addr, busy, done
  );
endinterface

// File: rtl/mul_mac_seq.sv
// Multi-cycle dot-product sequencer for the multiplier: issues term 0 as a
// product into MR, terms 1..N-1 as accumulate add/sub, then an optional
// saturated MR readout written back to the register file.
// Optional build macro: MUL_SEQ_STICKY_MV_EN adds the mv_sticky overflow output.
//
// state   | meaning
// IDLE    | waiting for start
// FIRST   | issue term 0 as product (cls 01) into MR
// ACC     | issue terms 1..N-1 as accumulate (cls 1,sub)
// RDOUT   | issue saturated MR readout (cls 00, otreg 0)
// DRAIN   | execute cycle of the last issue; writeback strobe if readout
// FIN     | one-cycle done pulse
module mul_mac_seq #(
  parameter int RF_DATASIZE = 16,
  parameter int RF_ADDRSIZE = 4,
  parameter int LEN_W       = 5
) (
  input  logic clk,
  input  logic reset,
  mul_mac_seq_if.slave bus
`ifdef MUL_SEQ_STICKY_MV_EN
  ,
  output logic mv_sticky
`endif
);

  // Data width only matters to the multiplier; reject nonsense at elaboration.
  if (RF_DATASIZE < 1) begin : g_bad_datasize
    $error("mul_mac_seq: RF_DATASIZE must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FIRST, S_ACC, S_RDOUT, S_DRAIN, S_FIN
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       rem_q;
  logic [RF_ADDRSIZE-1:0] rx_ptr_q, ry_ptr_q, rn_q;
  logic [3:0]             dtsts_q, hold_dtsts_q;
  logic                   sub_q, wb_q, hold_otreg_q;
  logic [1:0]             hold_cls_q;

  logic       accept, issue_st, issue;
  logic [1:0] cls_cur;
  logic       otreg_cur;

  assign accept   = (state_q == S_IDLE) && bus.start;
  assign issue_st = (state_q == S_FIRST) || (state_q == S_ACC) || (state_q == S_RDOUT);
  assign issue    = issue_st && !bus.stall;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; rem_q counts terms still to issue, terminal count at 1.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len != '0)   state_d = S_FIRST;
          else if (bus.wb_en)  state_d = S_RDOUT;
          else                 state_d = S_DRAIN;
        end
      end
      S_FIRST, S_ACC: begin
        if (issue) begin
          if (rem_q == LEN_W'(1)) state_d = wb_q ? S_RDOUT : S_DRAIN;
          else                    state_d = S_ACC;
        end
      end
      S_RDOUT: if (issue) state_d = S_DRAIN;
      S_DRAIN: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; multiplier controls show the live value on issue, else hold.
  always_comb begin
    cls_cur   = 2'b00;
    otreg_cur = 1'b0;
    unique case (state_q)
      S_FIRST: begin cls_cur = 2'b01;        otreg_cur = 1'b1; end
      S_ACC:   begin cls_cur = {1'b1, sub_q}; otreg_cur = 1'b1; end
      default: begin cls_cur = 2'b00;        otreg_cur = 1'b0; end
    endcase
    bus.ps_mul_en    = issue;
    bus.ps_mul_cls   = issue ? cls_cur   : hold_cls_q;
    bus.ps_mul_otreg = issue ? otreg_cur : hold_otreg_q;
    bus.ps_mul_dtsts = issue ? dtsts_q   : hold_dtsts_q;
    bus.rf_rx_addr   = rx_ptr_q;
    bus.rf_ry_addr   = ry_ptr_q;
    bus.rf_wr_en     = (state_q == S_DRAIN) && wb_q;
    bus.rf_wr_addr   = ((state_q == S_DRAIN) && wb_q) ? rn_q : '0;
    bus.busy         = (state_q != S_IDLE);
    bus.done         = (state_q == S_FIN);
  end

  // Command latch, term counter, operand pointers and held multiplier controls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q        <= '0;
      rx_ptr_q     <= '0;
      ry_ptr_q     <= '0;
      rn_q         <= '0;
      dtsts_q      <= '0;
      sub_q        <= 1'b0;
      wb_q         <= 1'b0;
      hold_cls_q   <= 2'b00;
      hold_otreg_q <= 1'b0;
      hold_dtsts_q <= '0;
    end else if (accept) begin
      rem_q    <= bus.len;
      rx_ptr_q <= bus.x_base;
      ry_ptr_q <= bus.y_base;
      rn_q     <= bus.rn_addr;
      dtsts_q  <= bus.dtsts;
      sub_q    <= bus.sub;
      wb_q     <= bus.wb_en;
    end else if (issue) begin
      hold_cls_q   <= cls_cur;
      hold_otreg_q <= otreg_cur;
      hold_dtsts_q <= dtsts_q;
      if (state_q != S_RDOUT) begin
        rem_q    <= rem_q - LEN_W'(1);
        rx_ptr_q <= rx_ptr_q + RF_ADDRSIZE'(1);
        ry_ptr_q <= ry_ptr_q + RF_ADDRSIZE'(1);
      end
    end
  end

`ifdef MUL_SEQ_STICKY_MV_EN
  logic exec_q;

  // Overflow flag is only meaningful in the cycle after an issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_q    <= 1'b0;
      mv_sticky <= 1'b0;
    end else begin
      exec_q <= issue;
      if (accept)                          mv_sticky <= 1'b0;
      else if (exec_q && bus.mul_ps_mv)    mv_sticky <= 1'b1;
    end
  end
`endif

endmodule
